// File: rtl/qracc_csr_bank_if.sv
// Control bus between a host and the QRAcc CSR bank: valid/ready request
// channel with a separate registered read-data return.
interface qracc_csr_bank_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              valid;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   modport master (
      output valid, wen, addr, data,
      input  ready, rd_data, rd_valid
   );

   modport slave (
      input  valid, wen, addr, data,
      output ready, rd_data, rd_valid
   );
endinterface

// File: rtl/qracc_csr_bank.sv
// QRAcc control/status register bank.
// CSR0 holds trigger/clear/mode/status, CSR1-6 the layer configuration,
// CSR7 and up are plain scratch registers. Reads are returned one cycle
// after acceptance. Optional macro QRACC_CSR_SHADOW_EN makes cfg_o come
// from a copy of CSR1-6 captured only when a trigger is accepted.
module qracc_csr_bank #(
   parameter int unsigned NUM_CSR        = 8,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned NUM_TRIG_VALID = 6
) (
   input  logic               clk,
   input  logic               nrst,
   qracc_csr_bank_if.slave    ctrl,
   input  logic               busy_i,
   input  logic [3:0]         state_i,
   output logic [2:0]         trigger_o,
   output logic               trigger_valid_o,
   output logic               clear_o,
   output logic               inst_write_mode_o,
   output logic [169:0]       cfg_o
);

   localparam int unsigned IdxW = ADDR_W - 2;

   logic              ready_q, rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [2:0]        trigger_q, trigger_d;
   logic              trigger_valid_q, trigger_valid_d;
   logic              clear_q, clear_d;
   logic              iwm_q, iwm_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] csr_q [NUM_CSR-1:1];
   logic [DATA_W-1:0] csr_d [NUM_CSR-1:1];

   logic [IdxW-1:0]   idx;
   logic              accept, wr, rd, in_range, csr0_hit;
   logic [2:0]        code;
   logic              trig_ok, err_set, err_clr;
   logic [DATA_W-1:0] csr0_view;
   logic [169:0]      cfg_work;
   logic              unused_addr;

   assign idx         = ctrl.addr[ADDR_W-1:2];
   assign unused_addr = ^ctrl.addr[1:0];
   assign accept      = ctrl.valid & ready_q;
   assign wr          = accept & ctrl.wen;
   assign rd          = accept & ~ctrl.wen;
   assign in_range    = (idx < IdxW'(NUM_CSR));
   assign csr0_hit    = (idx == '0);
   assign code        = ctrl.data[2:0];
   assign csr0_view   = {19'b0, err_q, state_i, 2'b0, iwm_q, busy_i, 4'b0};

   // Field order matches qracc_config_t, binary_cfg in the MSB.
   assign cfg_work = {csr_q[1][0], csr_q[1][1], csr_q[1][7:4], csr_q[1][11:8],
                      csr_q[1][15:12], csr_q[1][19:16], csr_q[1][23:20],
                      csr_q[1][27:24], csr_q[1][31:28],
                      csr_q[2][15:0], csr_q[2][31:16],
                      csr_q[3][15:0], csr_q[3][31:16],
                      csr_q[4][15:0], csr_q[4][31:16],
                      csr_q[5][15:0], csr_q[5][31:16],
                      csr_q[6][3:0], csr_q[6][11:4]};

   // Decode bus writes into CSR updates, pulses and the sticky error bit.
   always_comb begin
      csr_d           = csr_q;
      iwm_d           = iwm_q;
      trigger_d       = 3'd0;
      trigger_valid_d = 1'b0;
      clear_d         = 1'b0;
      trig_ok         = 1'b0;
      err_set         = 1'b0;
      err_clr         = 1'b0;
      if (wr) begin
         if (!in_range) begin
            err_set = 1'b1;
         end else if (csr0_hit) begin
            if (ctrl.data[3]) begin
               // Clear overrides any trigger code and leaves the mode bit alone.
               clear_d = 1'b1;
               err_clr = 1'b1;
            end else begin
               iwm_d = ctrl.data[5];
               if (ctrl.data[12]) err_clr = 1'b1;
               if (code != 3'd0) begin
                  if ((32'(code) < NUM_TRIG_VALID) && !busy_i) trig_ok = 1'b1;
                  else err_set = 1'b1;
               end
            end
         end else begin
            for (int unsigned i = 1; i < NUM_CSR; i++) begin
               if (idx == IdxW'(i)) begin
                  if (i == 1)      csr_d[i] = ctrl.data & 32'hFFFF_FFF3;
                  else if (i == 6) csr_d[i] = ctrl.data & 32'h0000_0FFF;
                  else             csr_d[i] = ctrl.data;
               end
            end
         end
      end
      if (rd && !in_range) err_set = 1'b1;
      if (trig_ok) begin
         trigger_d       = code;
         trigger_valid_d = 1'b1;
      end
      // A set event beats a same-cycle clear.
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   // Registered read-back path.
   always_comb begin
      rd_data_d  = '0;
      rd_valid_d = rd;
      if (rd && in_range) begin
         if (csr0_hit) begin
            rd_data_d = csr0_view;
         end else begin
            for (int unsigned i = 1; i < NUM_CSR; i++) begin
               if (idx == IdxW'(i)) rd_data_d = csr_q[i];
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ready_q         <= 1'b0;
         rd_valid_q      <= 1'b0;
         rd_data_q       <= '0;
         trigger_q       <= 3'd0;
         trigger_valid_q <= 1'b0;
         clear_q         <= 1'b0;
         iwm_q           <= 1'b0;
         err_q           <= 1'b0;
         for (int unsigned i = 1; i < NUM_CSR; i++) csr_q[i] <= '0;
      end else begin
         ready_q         <= 1'b1;
         rd_valid_q      <= rd_valid_d;
         rd_data_q       <= rd_data_d;
         trigger_q       <= trigger_d;
         trigger_valid_q <= trigger_valid_d;
         clear_q         <= clear_d;
         iwm_q           <= iwm_d;
         err_q           <= err_d;
         csr_q           <= csr_d;
      end
   end

`ifdef QRACC_CSR_SHADOW_EN
   logic [169:0] shadow_q, shadow_d;

   // Shadow captures the working config only when a layer is launched.
   always_comb begin
      shadow_d = trig_ok ? cfg_work : shadow_q;
   end

   // Shadow register.
   always_ff @(posedge clk) begin
      if (!nrst) shadow_q <= '0;
      else       shadow_q <= shadow_d;
   end

   assign cfg_o = shadow_q;
`else
   assign cfg_o = cfg_work;
`endif

   assign ctrl.ready         = ready_q;
   assign ctrl.rd_data       = rd_data_q;
   assign ctrl.rd_valid      = rd_valid_q;
   assign trigger_o          = trigger_q;
   assign trigger_valid_o    = trigger_valid_q;
   assign clear_o            = clear_q;
   assign inst_write_mode_o  = iwm_q;

endmodule

// File: tb/tb_qracc_csr_bank.sv
// Directed bench for qracc_csr_bank; expectations are hand-computed.
module tb_qracc_csr_bank;
   logic         clk = 1'b0;
   logic         nrst;
   logic         busy;
   logic [3:0]   state;
   logic [2:0]   trigger;
   logic         trigger_valid;
   logic         clear;
   logic         iwm;
   logic [169:0] cfg;
   int           checks = 0;
   int           errors = 0;

   qracc_csr_bank_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   qracc_csr_bank #(.NUM_CSR(8), .DATA_W(32), .ADDR_W(32), .NUM_TRIG_VALID(6)) dut (
      .clk               (clk),
      .nrst              (nrst),
      .ctrl              (bus),
      .busy_i            (busy),
      .state_i           (state),
      .trigger_o         (trigger),
      .trigger_valid_o   (trigger_valid),
      .clear_o           (clear),
      .inst_write_mode_o (iwm),
      .cfg_o             (cfg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [169:0] obs, input logic [169:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.valid = 1'b1;
      bus.wen   = 1'b1;
      bus.addr  = a;
      bus.data  = d;
      tick();
      bus.valid = 1'b0;
      bus.wen   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.valid = 1'b1;
      bus.wen   = 1'b0;
      bus.addr  = a;
      tick();
      bus.valid = 1'b0;
      chk({tag, "_rdv"}, 170'(bus.rd_valid), 170'(1));
      chk({tag, "_data"}, 170'(bus.rd_data), 170'(exp));
      tick();
      chk({tag, "_rdv_end"}, 170'(bus.rd_valid), 170'(0));
   endtask

   initial begin
      nrst      = 1'b0;
      busy      = 1'b0;
      state     = 4'd5;
      bus.valid = 1'b1;
      bus.wen   = 1'b1;
      bus.addr  = 32'h4;
      bus.data  = 32'hFFFF_FFFF;
      repeat (3) tick();
      chk("rst_ready", 170'(bus.ready), 170'(0));
      chk("rst_rdv", 170'(bus.rd_valid), 170'(0));
      chk("rst_rdata", 170'(bus.rd_data), 170'(0));
      chk("rst_trig", 170'({trigger, trigger_valid, clear, iwm}), 170'(0));
      chk("rst_cfg", cfg, 170'(0));
      nrst      = 1'b1;
      bus.valid = 1'b0;
      bus.wen   = 1'b0;
      tick();
      chk("ready_after_rst", 170'(bus.ready), 170'(1));

      // CSR1 write and config mapping
      wr(32'h4, 32'h3344_5561);
`ifdef QRACC_CSR_SHADOW_EN
      chk("cfg_shadow_hold", cfg, 170'(0));
`else
      chk("cfg_binary", 170'(cfg[169]), 170'(1));
      chk("cfg_adc", 170'(cfg[167:164]), 170'(6));
      chk("cfg_nin", 170'(cfg[147:144]), 170'(3));
      chk("cfg_nout", 170'(cfg[143:140]), 170'(3));
`endif
      rd("csr1", 32'h4, 32'h3344_5561);
      wr(32'h4, 32'h3344_556D);
      rd("csr1_mask", 32'h4, 32'h3344_5561);

      // Back-to-back reads
      bus.valid = 1'b1;
      bus.addr  = 32'h4;
      tick();
      chk("b2b_rdv0", 170'(bus.rd_valid), 170'(1));
      chk("b2b_data0", 170'(bus.rd_data), 170'(32'h3344_5561));
      bus.addr = 32'h0;
      tick();
      bus.valid = 1'b0;
      chk("b2b_rdv1", 170'(bus.rd_valid), 170'(1));
      chk("b2b_data1", 170'(bus.rd_data), 170'(32'h0000_0500));
      tick();
      chk("b2b_rdv_end", 170'(bus.rd_valid), 170'(0));

      // Legal trigger, idle controller
      wr(32'h0, 32'h3);
      chk("trig3_valid", 170'(trigger_valid), 170'(1));
      chk("trig3_code", 170'(trigger), 170'(3));
      chk("trig3_cfg", 170'(cfg[169]), 170'(1));
      tick();
      chk("trig3_end", 170'({trigger, trigger_valid}), 170'(0));

      // Trigger while busy sets err
      busy = 1'b1;
      wr(32'h0, 32'h3);
      chk("trig_busy", 170'(trigger_valid), 170'(0));
      rd("csr0_busy_err", 32'h0, 32'h0000_1510);
      busy = 1'b0;
      wr(32'h0, 32'h1000);
      rd("csr0_w1c", 32'h0, 32'h0000_0500);

      // Illegal code 7, then clear
      wr(32'h0, 32'h7);
      chk("trig7", 170'(trigger_valid), 170'(0));
      rd("csr0_err7", 32'h0, 32'h0000_1500);
      wr(32'h0, 32'hE);
      chk("clr_pulse", 170'(clear), 170'(1));
      chk("clr_notrig", 170'(trigger_valid), 170'(0));
      tick();
      chk("clr_end", 170'(clear), 170'(0));
      rd("csr0_after_clr", 32'h0, 32'h0000_0500);
      rd("csr1_after_clr", 32'h4, 32'h3344_5561);

      // Instruction write mode
      wr(32'h0, 32'h20);
      chk("iwm_set", 170'(iwm), 170'(1));
      rd("csr0_iwm", 32'h0, 32'h0000_0520);
      wr(32'h0, 32'h0);
      chk("iwm_clr", 170'(iwm), 170'(0));

      // Trigger code boundary and err precedence
      wr(32'h0, 32'h5);
      chk("trig5_valid", 170'(trigger_valid), 170'(1));
      chk("trig5_code", 170'(trigger), 170'(5));
      wr(32'h0, 32'h6);
      chk("trig6", 170'(trigger_valid), 170'(0));
      wr(32'h0, 32'h1007);
      chk("trig7_w1c", 170'(trigger_valid), 170'(0));
      rd("csr0_prec", 32'h0, 32'h0000_1500);
      wr(32'h0, 32'h1000);
      rd("csr0_clean", 32'h0, 32'h0000_0500);

      // Out-of-range accesses
      rd("oor_rd", 32'h40, 32'h0);
      rd("csr0_oor_rd", 32'h0, 32'h0000_1500);
      wr(32'h0, 32'h1000);
      wr(32'h20, 32'h1234_5678);
      rd("csr0_oor_wr", 32'h0, 32'h0000_1500);
      wr(32'h0, 32'h1000);

      // Scratch and CSR6 masking
      wr(32'h1C, 32'hDEAD_BEEF);
      rd("csr7", 32'h1C, 32'hDEAD_BEEF);
      wr(32'h18, 32'hFFFF_FFFF);
      rd("csr6_mask", 32'h18, 32'h0000_0FFF);
`ifndef QRACC_CSR_SHADOW_EN
      chk("cfg_pad", 170'(cfg[11:0]), 170'(12'hFFF));
`endif

      // Channel config across a trigger
      wr(32'h10, 32'h0010_0008);
      wr(32'h0, 32'h3);
      chk("ch_in_trig", 170'(cfg[75:60]), 170'(16'h0008));
      chk("ch_out_trig", 170'(cfg[59:44]), 170'(16'h0010));
      wr(32'h10, 32'h1);
`ifdef QRACC_CSR_SHADOW_EN
      chk("ch_in_hold", 170'(cfg[75:60]), 170'(16'h0008));
      chk("ch_out_hold", 170'(cfg[59:44]), 170'(16'h0010));
`else
      chk("ch_in_live", 170'(cfg[75:60]), 170'(16'h0001));
      chk("ch_out_live", 170'(cfg[59:44]), 170'(16'h0000));
`endif
      wr(32'h0, 32'h3);
      chk("ch_in_retrig", 170'(cfg[75:60]), 170'(16'h0001));
      chk("ch_out_retrig", 170'(cfg[59:44]), 170'(16'h0000));

      // Reset while a read is presented
      bus.valid = 1'b1;
      bus.wen   = 1'b0;
      bus.addr  = 32'h4;
      nrst      = 1'b0;
      tick();
      chk("rst_rd_rdv", 170'(bus.rd_valid), 170'(0));
      chk("rst_rd_ready", 170'(bus.ready), 170'(0));
      chk("rst_rd_cfg", cfg, 170'(0));
      tick();
      chk("rst_rd_rdv2", 170'(bus.rd_valid), 170'(0));
      bus.valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
